// File: rtl/instruction_ram_loader_if.sv
// Byte-stream input and instruction-RAM write port of the loader.
// The master modport is the loader side; the slave modport is the byte source and RAM side.
interface instruction_ram_loader_if;
  logic [7:0]  byte_in;
  logic        byte_valid;
  logic        byte_ready;
  logic [31:0] i_ram_input;
  logic [9:0]  i_ram_writing_address;
  logic        flag_write_i_ram;

  modport master (
    input  byte_in,
    input  byte_valid,
    output byte_ready,
    output i_ram_input,
    output i_ram_writing_address,
    output flag_write_i_ram
  );

  modport slave (
    output byte_in,
    output byte_valid,
    input  byte_ready,
    input  i_ram_input,
    input  i_ram_writing_address,
    input  flag_write_i_ram
  );
endinterface

// File: rtl/instruction_ram_loader.sv
// Loads a count-prefixed big-endian byte stream into instruction RAM: 4 accepted bytes then 1 write cycle per word.
// byte_ready is low outside COUNT/DATA and whenever abort is high, so the source simply stalls.
module instruction_ram_loader #(
  parameter int MAX_WORDS = 31
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            start,
  input  logic                            abort,
  instruction_ram_loader_if.master        bus,
  output logic                            cpu_hold,
  output logic                            done,
  output logic                            error,
  output logic [9:0]                      words_loaded
);

  localparam logic [9:0] MAX_N = 10'(MAX_WORDS);

  typedef enum logic [2:0] {
    IDLE,
    COUNT,
    DATA,
    WRITE,
    DONE,
    ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  n_q, n_d;
  logic [1:0]  idx_q, idx_d;
  logic [23:0] part_q, part_d;
  logic [9:0]  wl_q, wl_d;
  logic [31:0] din_q, din_d;
  logic [9:0]  addr_q, addr_d;
  logic        accept;
  logic [9:0]  wl_inc;

  // Abort withdraws ready so a byte offered in an abort cycle is never consumed.
  assign bus.byte_ready = ((state_q == COUNT) || (state_q == DATA)) && !abort;
  assign accept         = bus.byte_valid && bus.byte_ready;
  assign wl_inc         = wl_q + 10'd1;

  always_comb begin
    state_d = state_q;
    n_d     = n_q;
    idx_d   = idx_q;
    part_d  = part_q;
    wl_d    = wl_q;
    din_d   = din_q;
    addr_d  = addr_q;
    case (state_q)
      IDLE, DONE, ERROR: begin
        if (start) begin
          state_d = COUNT;
          wl_d    = 10'd0;
          idx_d   = 2'd0;
        end
      end
      COUNT: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          n_d = bus.byte_in;
          if ((bus.byte_in == 8'd0) || ({2'b00, bus.byte_in} > MAX_N)) begin
            state_d = ERROR;
          end else begin
            state_d = DATA;
            idx_d   = 2'd0;
          end
        end
      end
      DATA: begin
        if (abort) begin
          state_d = IDLE;
        end else if (accept) begin
          part_d = {part_q[15:0], bus.byte_in};
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) begin
            state_d = WRITE;
            din_d   = {part_q, bus.byte_in};
            addr_d  = wl_q;
          end
        end
      end
      WRITE: begin
        // The write itself is unconditional; abort only redirects where we go next.
        wl_d = wl_inc;
        if (abort) begin
          state_d = IDLE;
        end else if (wl_inc == {2'b00, n_q}) begin
          state_d = DONE;
        end else begin
          state_d = DATA;
          idx_d   = 2'd0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      n_q     <= 8'd0;
      idx_q   <= 2'd0;
      part_q  <= 24'd0;
      wl_q    <= 10'd0;
      din_q   <= 32'd0;
      addr_q  <= 10'd0;
    end else begin
      state_q <= state_d;
      n_q     <= n_d;
      idx_q   <= idx_d;
      part_q  <= part_d;
      wl_q    <= wl_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
    end
  end

  assign bus.flag_write_i_ram      = (state_q == WRITE);
  assign bus.i_ram_input           = din_q;
  assign bus.i_ram_writing_address = addr_q;
  assign cpu_hold                  = (state_q == COUNT) || (state_q == DATA) || (state_q == WRITE);
  assign done                      = (state_q == DONE);
  assign error                     = (state_q == ERROR);
  assign words_loaded              = wl_q;

endmodule

// File: tb/tb_instruction_ram_loader.sv
// Randomized and directed bench for instruction_ram_loader against a load-level reference model.
// The model tracks bytes accepted per load; a write is due whenever a full word is buffered but not yet written.
module tb_instruction_ram_loader;

  localparam int MAXW = 31;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       abort;
  logic       cpu_hold;
  logic       done;
  logic       error;
  logic [9:0] words_loaded;

  always #5 clock = ~clock;

  instruction_ram_loader_if bus ();

  instruction_ram_loader #(.MAX_WORDS(MAXW)) dut (
    .clock        (clock),
    .reset        (reset),
    .start        (start),
    .abort        (abort),
    .bus          (bus),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: one load = count byte, then data bytes kept in order.
  bit          m_busy = 1'b0;
  bit          m_have_n = 1'b0;
  bit          m_done = 1'b0;
  bit          m_err = 1'b0;
  int          m_n = 0;
  int          m_nbytes = 0;
  int          m_words = 0;
  logic [7:0]  m_bytes [0:127];
  logic [31:0] m_last_data = 32'd0;
  logic [9:0]  m_last_addr = 10'd0;

  logic [9:0]  wa [$];
  logic [31:0] wd [$];

  function automatic bit m_wr();
    return m_busy && m_have_n && (m_nbytes == 4 * (m_words + 1));
  endfunction

  function automatic bit m_ready();
    return m_busy && !m_wr() && !abort;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(posedge clock or negedge reset) begin : model_upd
    bit wr;
    bit acc;
    int k;
    if (!reset) begin
      m_busy = 0; m_have_n = 0; m_done = 0; m_err = 0;
      m_n = 0; m_nbytes = 0; m_words = 0;
      m_last_data = 32'd0; m_last_addr = 10'd0;
    end else begin
      wr  = m_wr();
      acc = bus.byte_valid && m_ready();
      if (!m_busy) begin
        if (start) begin
          m_busy = 1; m_have_n = 0; m_nbytes = 0; m_words = 0; m_done = 0; m_err = 0;
        end
      end else if (abort) begin
        if (wr) m_words++;
        m_busy = 0;
      end else if (wr) begin
        m_words++;
        if (m_words == m_n) begin
          m_busy = 0;
          m_done = 1;
        end
      end else if (acc) begin
        if (!m_have_n) begin
          if (bus.byte_in == 8'd0 || int'(bus.byte_in) > MAXW) begin
            m_busy = 0;
            m_err  = 1;
          end else begin
            m_have_n = 1;
            m_n      = int'(bus.byte_in);
          end
        end else begin
          m_bytes[m_nbytes] = bus.byte_in;
          m_nbytes++;
          if (m_nbytes % 4 == 0) begin
            k = m_nbytes / 4 - 1;
            m_last_data = {m_bytes[4*k], m_bytes[4*k+1], m_bytes[4*k+2], m_bytes[4*k+3]};
            m_last_addr = 10'(k);
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    chk("byte_ready", 32'(bus.byte_ready), 32'(m_ready()));
    chk("flag_write_i_ram", 32'(bus.flag_write_i_ram), 32'(m_wr()));
    chk("i_ram_input", bus.i_ram_input, m_last_data);
    chk("i_ram_writing_address", 32'(bus.i_ram_writing_address), 32'(m_last_addr));
    chk("cpu_hold", 32'(cpu_hold), 32'(m_busy));
    chk("done", 32'(done), 32'(m_done));
    chk("error", 32'(error), 32'(m_err));
    chk("words_loaded", 32'(words_loaded), 32'(m_words));
    if (bus.flag_write_i_ram) begin
      wa.push_back(bus.i_ram_writing_address);
      wd.push_back(bus.i_ram_input);
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    bit ok;
    ok = 0;
    bus.byte_in    = b;
    bus.byte_valid = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      ok = bus.byte_ready;
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL send_byte: byte 0x%0h not accepted, got no ready in 20 cycles, expected ready", b);
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic idle(input int n);
    bus.byte_valid = 1'b0;
    repeat (n) tick();
  endtask

  logic [7:0] s41 [9] = '{8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
  logic [7:0] s43 [4] = '{8'hC0, 8'hFF, 8'hEE, 8'h11};
  logic [7:0] s44 [4] = '{8'h5A, 8'h11, 8'h22, 8'h33};

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    reset = 1'b1; start = 1'b0; abort = 1'b0;
    bus.byte_valid = 1'b0; bus.byte_in = 8'h00;
    #1 reset = 1'b0;
    #3;
    chk("rst_ready", 32'(bus.byte_ready), 0);
    chk("rst_hold", 32'(cpu_hold), 0);
    chk("rst_words", 32'(words_loaded), 0);
    chk("rst_data", bus.i_ram_input, 0);
    repeat (2) @(posedge clock);
    #3 reset = 1'b1;
    tick();

    // Two-word load, back-to-back bytes.
    base = wa.size();
    pulse_start();
    foreach (s41[i]) send_byte(s41[i]);
    idle(3);
    chk("s41_nwrites", 32'(wa.size() - base), 2);
    chk("s41_addr0", 32'(wa[base]), 0);
    chk("s41_data0", wd[base], 32'hDEADBEEF);
    chk("s41_addr1", 32'(wa[base+1]), 1);
    chk("s41_data1", wd[base+1], 32'h01234567);
    chk("s41_done", 32'(done), 1);
    chk("s41_words", 32'(words_loaded), 2);
    chk("s41_hold", 32'(cpu_hold), 0);

    // Illegal counts 0 and 32.
    base = wa.size();
    pulse_start();
    send_byte(8'd0);
    idle(1);
    chk("s42a_error", 32'(error), 1);
    chk("s42a_hold", 32'(cpu_hold), 0);
    pulse_start();
    chk("s42_error_cleared", 32'(error), 0);
    chk("s42_hold_set", 32'(cpu_hold), 1);
    send_byte(8'd32);
    idle(1);
    chk("s42b_error", 32'(error), 1);
    chk("s42_nwrites", 32'(wa.size() - base), 0);

    // N=1 with a gap after every byte.
    base = wa.size();
    pulse_start();
    send_byte(8'd1);
    idle(1);
    foreach (s43[i]) begin
      send_byte(s43[i]);
      idle(1);
    end
    idle(2);
    chk("s43_nwrites", 32'(wa.size() - base), 1);
    chk("s43_addr", 32'(wa[base]), 0);
    chk("s43_data", wd[base], 32'hC0FFEE11);
    chk("s43_done", 32'(done), 1);

    // Abort mid-word, then a clean reload.
    base = wa.size();
    pulse_start();
    send_byte(8'd2);
    send_byte(8'hAA);
    send_byte(8'hBB);
    bus.byte_valid = 1'b0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("s44_hold", 32'(cpu_hold), 0);
    chk("s44_done", 32'(done), 0);
    chk("s44_error", 32'(error), 0);
    chk("s44_nwrites_abort", 32'(wa.size() - base), 0);
    idle(2);
    pulse_start();
    send_byte(8'd1);
    foreach (s44[i]) send_byte(s44[i]);
    idle(3);
    chk("s44_nwrites", 32'(wa.size() - base), 1);
    chk("s44_addr", 32'(wa[base]), 0);
    chk("s44_data", wd[base], 32'h5A112233);

    // Asynchronous reset during word 3 of N=5.
    base = wa.size();
    pulse_start();
    send_byte(8'd5);
    for (int i = 0; i < 13; i++) send_byte(8'(i * 17 + 3));
    bus.byte_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    chk("s45_ready", 32'(bus.byte_ready), 0);
    chk("s45_flag", 32'(bus.flag_write_i_ram), 0);
    chk("s45_data", bus.i_ram_input, 0);
    chk("s45_addr", 32'(bus.i_ram_writing_address), 0);
    chk("s45_hold", 32'(cpu_hold), 0);
    chk("s45_done", 32'(done), 0);
    chk("s45_error", 32'(error), 0);
    chk("s45_words", 32'(words_loaded), 0);
    chk("s45_nwrites", 32'(wa.size() - base), 3);
    repeat (3) @(posedge clock);
    #3 reset = 1'b1;
    idle(3);
    chk("s45_nwrites_after", 32'(wa.size() - base), 3);

    // Full-depth load with stray start pulses.
    base = wa.size();
    pulse_start();
    send_byte(8'd31);
    for (int i = 0; i < 124; i++) begin
      start = (i % 9 == 0);
      send_byte(8'($urandom));
    end
    start = 1'b0;
    idle(3);
    chk("s46_nwrites", 32'(wa.size() - base), 31);
    chk("s46_last_addr", 32'(wa[base+30]), 30);
    chk("s46_done", 32'(done), 1);
    chk("s46_words", 32'(words_loaded), 31);

    // Random traffic: starts, aborts, gaps and occasional illegal counts.
    for (int c = 0; c < 3000; c++) begin
      start          = ($urandom_range(0, 99) < 6);
      abort          = ($urandom_range(0, 99) < 1);
      bus.byte_valid = ($urandom_range(0, 99) < 70);
      if (m_busy && !m_have_n)
        bus.byte_in = ($urandom_range(0, 7) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(1, 6));
      else
        bus.byte_in = 8'($urandom);
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
